// File: rtl/rgr_pkg.sv
// Shared types and helpers for the row gather router.
package rgr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    typedef int unsigned uint_t;

    // Upper bounds for the generic element-extract helper.
    localparam int MAX_SPAD_W = 1024;
    localparam int MAX_DATA_W = 64;

    function automatic int calc_lanes(input int spad_w, input int data_w);
        return spad_w / data_w;
    endfunction

    function automatic int calc_lane_bits(input int lanes);
        return $clog2(lanes);
    endfunction

    function automatic int calc_word_aw(input int addr_w, input int lane_bits);
        return addr_w - lane_bits;
    endfunction

    // Pull element `lane` (data_w bits wide, lane 0 in the LSBs) out of a word.
    function automatic logic [MAX_DATA_W-1:0] extract_elem(
        input logic [MAX_SPAD_W-1:0] word,
        input uint_t                 lane,
        input uint_t                 data_w
    );
        logic [MAX_DATA_W-1:0] mask;
        mask = (data_w >= uint_t'(MAX_DATA_W)) ? '1
             : ((MAX_DATA_W'(1) << data_w) - MAX_DATA_W'(1));
        return MAX_DATA_W'(word >> (lane * data_w)) & mask;
    endfunction

endpackage

// File: rtl/row_gather_router_if.sv
// Load, broadcast, output-stream and status signals of the row gather router.
interface row_gather_router_if
    import rgr_pkg::*;
#(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int ADDR_LENGTH     = 9
);
    localparam int LANES   = calc_lanes(SPAD_DATA_WIDTH, DATA_WIDTH);
    localparam int WORD_AW = calc_word_aw(ADDR_WIDTH, calc_lane_bits(LANES));
    localparam int REM_W   = $clog2(ADDR_LENGTH + 1);

    logic                                   i_clear;
    logic                                   i_load;
    logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] i_addr_vec;
    logic                                   o_load_ready;
    logic                                   i_data_valid;
    logic [WORD_AW-1:0]                     i_word_addr;
    logic [SPAD_DATA_WIDTH-1:0]             i_data;
    logic [DATA_WIDTH-1:0]                  o_data;
    logic                                   o_valid;
    logic                                   i_ready;
    logic                                   o_busy;
    logic                                   o_done;
    logic [REM_W-1:0]                       o_remaining;

    // Router side.
    modport slave (
        input  i_clear, i_load, i_addr_vec, i_data_valid, i_word_addr, i_data, i_ready,
        output o_load_ready, o_data, o_valid, o_busy, o_done, o_remaining
    );

    // Controller / consumer side.
    modport master (
        output i_clear, i_load, i_addr_vec, i_data_valid, i_word_addr, i_data, i_ready,
        input  o_load_ready, o_data, o_valid, o_busy, o_done, o_remaining
    );

endinterface

// File: rtl/rgr_out_fifo.sv
// Multi-push (up to PUSH_MAX per cycle), single-pop FIFO with free-slot count.
module rgr_out_fifo #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 32,
    parameter  int PUSH_MAX   = 8,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = $clog2(DEPTH + 1),
    localparam int PW         = $clog2(PUSH_MAX + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic [PW-1:0]                      push_cnt,
    input  logic [PUSH_MAX-1:0][DATA_WIDTH-1:0] push_data,
    input  logic                               pop,
    output logic [DATA_WIDTH-1:0]              head_data,
    output logic                               valid,
    output logic [CW-1:0]                      level,
    output logic [CW-1:0]                      free_cnt
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic                  pop_fire;

    assign pop_fire  = pop && (count != '0);
    assign valid     = (count != '0);
    assign level     = count;
    // A slot vacated by this cycle's pop can be refilled in the same cycle.
    assign free_cnt  = CW'(DEPTH) - count + CW'(pop_fire);
    // Gate the head so the output reads zero while empty.
    assign head_data = valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_fire);
            wr_ptr <= wr_ptr + AW'(push_cnt);
            count  <= count + CW'(push_cnt) - CW'(pop_fire);
        end
    end

    // Storage write: push_cnt consecutive slots starting at wr_ptr.
    // NOTE: the storage array is not reset; emptiness comes from count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_MAX; i++) begin
            if (PW'(i) < push_cnt) begin
                mem[wr_ptr + AW'(i)] <= push_data[i];
            end
        end
    end

endmodule

// File: rtl/row_gather_router.sv
// Gathers one row window of byte addresses from the broadcast scratchpad
// stream, capturing out of order within a look-ahead window and retiring in order.
module row_gather_router
    import rgr_pkg::*;
#(
    parameter int SPAD_DATA_WIDTH = 64,
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 8,
    parameter int ADDR_LENGTH     = 9,
    parameter int PEEK_WIDTH      = 8,
    parameter int OUT_DEPTH       = 32
) (
    input logic                i_clk,
    input logic                i_rst,
    row_gather_router_if.slave bus
);
    localparam int LANES     = calc_lanes(SPAD_DATA_WIDTH, DATA_WIDTH);
    localparam int LANE_BITS = calc_lane_bits(LANES);
    localparam int REM_W     = $clog2(ADDR_LENGTH + 1);
    localparam int PW        = $clog2(PEEK_WIDTH + 1);
    localparam int FW        = $clog2(OUT_DEPTH + 1);

    state_t                              state;
    logic [ADDR_WIDTH-1:0]               addr_q [ADDR_LENGTH];
    logic [DATA_WIDTH-1:0]               data_q [ADDR_LENGTH];
    logic [ADDR_LENGTH-1:0]              captured;
    logic [REM_W-1:0]                    head;
    logic [REM_W-1:0]                    remaining;
    logic                                done_q;

    logic                                gathering;
    logic [ADDR_LENGTH-1:0]              hit;
    logic [ADDR_LENGTH-1:0]              cap_now;
    logic [DATA_WIDTH-1:0]               byte_now [ADDR_LENGTH];
    logic [PW-1:0]                       retire_cnt;
    logic [PEEK_WIDTH-1:0][DATA_WIDTH-1:0] push_data;
    logic [FW-1:0]                       free_cnt;
    logic [FW-1:0]                       fifo_level;
    logic                                fifo_valid;
    logic [DATA_WIDTH-1:0]               fifo_data;
    logic                                pop_fire;

    // A clear in the same cycle suppresses all capture and retire activity.
    assign gathering = (state == GATHER) && !bus.i_clear;
    assign pop_fire  = bus.i_ready && fifo_valid;

    // Match the broadcast word against uncaptured entries inside the window.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        hit     = '0;
        cap_now = captured;
        for (int e = 0; e < ADDR_LENGTH; e++) begin
            byte_now[e] = data_q[e];
            if (gathering && bus.i_data_valid && !captured[e]
                && e >= int'(head) && e < int'(head) + PEEK_WIDTH
                && addr_q[e][ADDR_WIDTH-1:LANE_BITS] == bus.i_word_addr) begin
                hit[e]      = 1'b1;
                cap_now[e]  = 1'b1;
                byte_now[e] = DATA_WIDTH'(extract_elem(MAX_SPAD_W'(bus.i_data),
                                                       uint_t'(addr_q[e][LANE_BITS-1:0]),
                                                       uint_t'(DATA_WIDTH)));
            end
        end
    end

    // Count the contiguous captured run from head, limited by FIFO space and PEEK_WIDTH.
    always_comb begin
        int   idx;
        logic stop;
        idx        = 0;
        stop       = 1'b0;
        retire_cnt = '0;
        push_data  = '0;
        for (int j = 0; j < PEEK_WIDTH; j++) begin
            idx = int'(head) + j;
            if (!stop && gathering && idx < ADDR_LENGTH && j < int'(free_cnt) && cap_now[idx]) begin
                retire_cnt   = retire_cnt + PW'(1);
                push_data[j] = byte_now[idx];
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Control FSM: load, gather/retire, drain, done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            head      <= '0;
            remaining <= '0;
            captured  <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every branch sees the pre-edge state.
            done_q <= 1'b0;
            if (bus.i_clear) begin
                state     <= IDLE;
                head      <= '0;
                remaining <= '0;
                captured  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.i_load) begin
                            state     <= GATHER;
                            head      <= '0;
                            captured  <= '0;
                            remaining <= REM_W'(ADDR_LENGTH);
                        end
                    end
                    GATHER: begin
                        captured  <= cap_now;
                        head      <= head + REM_W'(retire_cnt);
                        remaining <= remaining - REM_W'(retire_cnt);
                        if (int'(head) + int'(retire_cnt) == ADDR_LENGTH) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (fifo_level == '0 || (fifo_level == FW'(1) && pop_fire)) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Address latch on load and per-entry byte capture on a hit.
    always_ff @(posedge i_clk) begin
        if (state == IDLE && bus.i_load && !bus.i_clear) begin
            for (int e = 0; e < ADDR_LENGTH; e++) begin
                addr_q[e] <= bus.i_addr_vec[e];
            end
        end
        for (int e = 0; e < ADDR_LENGTH; e++) begin
            if (hit[e]) begin
                data_q[e] <= byte_now[e];
            end
        end
    end

    rgr_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OUT_DEPTH),
        .PUSH_MAX   (PEEK_WIDTH)
    ) u_out_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (bus.i_clear),
        .push_cnt  (retire_cnt),
        .push_data (push_data),
        .pop       (bus.i_ready),
        .head_data (fifo_data),
        .valid     (fifo_valid),
        .level     (fifo_level),
        .free_cnt  (free_cnt)
    );

    assign bus.o_data       = fifo_data;
    assign bus.o_valid      = fifo_valid;
    assign bus.o_load_ready = (state == IDLE);
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_done       = done_q;
    assign bus.o_remaining  = remaining;

endmodule
